uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: DATA_BITS, default 8, number of data bits per frame (LSB first, no parity, one stop bit).
REQ-002 Parameter: OVERSAMPLE, default 16, tick pulses per bit period; SHALL be even and >= 4.
REQ-003 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port: reset_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: tick  input  1  one-clk strobe at OVERSAMPLE x baud rate, from the baud generator.
REQ-006 Port: rx  input  1  asynchronous serial line, idle high.
REQ-007 Port: rx_data  output  DATA_BITS  last correctly framed byte.
REQ-008 Port: rx_valid  output  1  one-clk pulse when rx_data is updated.
REQ-009 Port: frame_err  output  1  one-clk pulse when the stop bit samples low.
REQ-010 Port: busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer, both flops reset to 1; all FSM decisions SHALL use the synchronized value (rx_s).
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; tick_cnt is $clog2(OVERSAMPLE) bits; bit_cnt counts 0..DATA_BITS-1.
REQ-013 The FSM and its counters SHALL advance only on cycles with tick=1; with tick=0 all state holds.
REQ-014 IDLE: on tick with rx_s=0 -> START, tick_cnt=0; otherwise stay.
REQ-015 START: on each tick, tick_cnt increments; on the tick where tick_cnt==OVERSAMPLE/2-1 (mid start bit), rx_s=0 -> DATA with tick_cnt=0, bit_cnt=0; rx_s=1 -> IDLE (glitch rejected, no output pulse).
REQ-016 DATA: on the tick where tick_cnt==OVERSAMPLE-1, rx_s SHALL be shifted into the MSB of the shift register (right shift, LSB first on the line), tick_cnt=0, bit_cnt increments; the sample of bit DATA_BITS-1 moves to STOP.
REQ-017 STOP: on the tick where tick_cnt==OVERSAMPLE-1 the stop bit is sampled and the FSM SHALL return to IDLE on the same edge (half-bit early, allowing resync to the next start edge).
REQ-018 Stop sample rx_s=1: rx_data <= shift register and rx_valid=1 on the following cycle only.
REQ-019 Stop sample rx_s=0: frame_err=1 on the following cycle only; rx_data SHALL hold its previous value; rx_valid stays 0.
REQ-020 rx_valid and frame_err SHALL never be high in the same cycle and SHALL each be high at most one clk per frame.
REQ-021 Latency: rx line falling edge to rx_valid = 2 clk (sync) + (OVERSAMPLE/2 + DATA_BITS*OVERSAMPLE + OVERSAMPLE) ticks + 1 clk, ± 1 tick for edge detection quantisation.
REQ-022 A new start bit arriving while the FSM is in IDLE immediately after STOP SHALL be accepted with no lost tick.
REQ-023 busy SHALL be combinational from state (state != IDLE) or registered with equal timing; it SHALL be 0 in IDLE.

Reset
REQ-024 On reset_n=0, asynchronously: state=IDLE, tick_cnt=0, bit_cnt=0, shift register=0, rx_data=0, rx_valid=0, frame_err=0, synchronizer flops=1, busy=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no rx_valid or frame_err pulse; after release the block SHALL wait in IDLE for the next falling edge of rx_s.

Verification
REQ-026 tick every clk, send 0xA5 as 8N1 (16 ticks/bit) -> exactly one rx_valid pulse with rx_data=0xA5, frame_err never high.
REQ-027 tick every 54 clk, send 0x3C with stop bit driven low -> one frame_err pulse, no rx_valid, rx_data keeps prior value (0x00 after reset).
REQ-028 rx low for 4 ticks then high (glitch) -> FSM returns to IDLE at the 8th tick, no pulses; following 0x5A frame received correctly.
REQ-029 Back-to-back 0x00 then 0xFF with no idle gap -> two rx_valid pulses, rx_data=0x00 then 0xFF.
REQ-030 reset_n pulsed low during bit 3 of 0x81, then 0x7E sent -> no pulse for the aborted frame, one rx_valid with rx_data=0x7E; all outputs 0 during reset.
REQ-031 tick held low for 1000 clk mid-frame -> state, counters and outputs frozen; frame completes correctly once ticks resume.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: 2-flop synced rx, mid-bit sampling on OVERSAMPLE ticks, no backpressure.
// Latency: 2 clk sync + (OVERSAMPLE/2 + DATA_BITS*OVERSAMPLE + OVERSAMPLE) ticks + 1 clk to rx_valid/frame_err.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 rx_meta_q, rx_s_q;
  logic [1:0]           state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_d, rx_valid_q;
  logic                 frame_err_d, frame_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d    = S_START;
            tick_cnt_d = '0;
          end
        end
        S_START: begin
          if (tick_cnt_q == T_HALF) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            // A high line at mid start bit was only a glitch
            state_d    = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        S_DATA: begin
          if (tick_cnt_q == T_FULL) begin
            shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + BW'(1);
            if (bit_cnt_q == B_LAST) state_d = S_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
        default: begin
          // Leave at mid stop bit so the next start edge is never missed
          if (tick_cnt_q == T_FULL) begin
            state_d    = S_IDLE;
            tick_cnt_d = '0;
            if (rx_s_q) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected results, a monitor pops on each pulse.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, busy;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         tick_div = 1;
  bit         tick_en = 1'b1;
  logic [7:0] last_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Baud tick generator; tick changes on negedge so the DUT samples it cleanly
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        cnt = cnt + 1;
        if (cnt >= tick_div) begin
          cnt = 0;
          tick = 1'b1;
        end else begin
          tick = 1'b0;
        end
      end else begin
        tick = 1'b0;
      end
    end
  end

  // Monitor: every output pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rx_valid && frame_err) chk("both_pulses", 32'd1, 32'd0);
    if (rx_valid || frame_err) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, rx_valid, frame_err}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_kind", {31'd0, frame_err}, {31'd0, e.is_err});
        chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation hung at %0t", $time);
    $fatal(1);
  end

  task automatic wait_tick();
    do @(posedge clk); while (tick !== 1'b1);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    rx = b;
    repeat (16) wait_tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic expect_ok(input logic [7:0] d);
    exp_t e;
    e.is_err = 1'b0;
    e.data = d;
    exp_q.push_back(e);
    last_data = d;
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data = last_data;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk(name, exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    rx = 1'b1;
    #1;
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    last_data = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    do_reset();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // 0xA5 with a tick every clock
    expect_ok(8'hA5);
    send_frame(8'hA5, 1'b1);
    drain("drain_a5");
    chk("a5_data_held", {24'd0, rx_data}, 32'h000000A5);

    // 0x3C with stop bit low at tick every 54 clk: frame error, data stays 0x00
    do_reset();
    tick_div = 54;
    expect_err();
    send_frame(8'h3C, 1'b0);
    @(negedge clk);
    rx = 1'b1;
    drain("drain_3c");
    chk("3c_data_held", {24'd0, rx_data}, 32'h00000000);
    repeat (16 * 54) @(negedge clk);
    tick_div = 1;
    repeat (40) @(negedge clk);

    // Glitch: low for 4 ticks then high; START must reject it
    @(negedge clk);
    rx = 1'b0;
    repeat (4) wait_tick();
    @(negedge clk);
    chk("glitch_busy_hi", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (10) wait_tick();
    @(negedge clk);
    chk("glitch_busy_lo", {31'd0, busy}, 32'd0);
    repeat (20) @(negedge clk);
    expect_ok(8'h5A);
    send_frame(8'h5A, 1'b1);
    drain("drain_5a");

    // Back-to-back frames, no idle gap
    expect_ok(8'h00);
    expect_ok(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drain("drain_b2b");
    chk("b2b_last", {24'd0, rx_data}, 32'h000000FF);

    // Reset during bit 3 of 0x81, then 0x7E
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1 & (i == 0));
    @(negedge clk);
    rx = 1'b0;
    repeat (5) wait_tick();
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    do_reset();
    repeat (48) wait_tick();
    chk("abort_busy_post", {31'd0, busy}, 32'd0);
    expect_ok(8'h7E);
    send_frame(8'h7E, 1'b1);
    drain("drain_7e");

    // Tick stall mid-frame: everything frozen, frame still completes
    expect_ok(8'h96);
    fork
      send_frame(8'h96, 1'b1);
      begin
        repeat (16 * 5 + 3) wait_tick();
        @(negedge clk);
        tick_en = 1'b0;
        @(negedge clk);
        chk("freeze_busy_start", {31'd0, busy}, 32'd1);
        repeat (1000) @(negedge clk);
        chk("freeze_busy_end", {31'd0, busy}, 32'd1);
        chk("freeze_data", {24'd0, rx_data}, 32'h0000007E);
        chk("freeze_q_pending", exp_q.size(), 32'd1);
        tick_en = 1'b1;
      end
    join
    drain("drain_96");
    repeat (20) @(negedge clk);
    chk("final_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
